branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised successor to the pipeline's combinational branch decision logic. It resolves conditional branches in EX for five condition codes and predicts taken/not-taken at IF from a table of saturating counters indexed by PC. It trains the table on every resolved branch, drives mispredict and redirect signals to the PC mux and the flush logic, and keeps saturating branch and mispredict statistics.

## Interface
- `PC_W`, 16: PC width in bits.
- `IDX_W`, 4: table index width; the table has 2^IDX_W entries, indexed by `pc[IDX_W:1]` (halfword-aligned PCs).
- `CNT_W`, 2: saturating counter width, minimum 1.
- `STAT_W`, 16: width of the statistics counters.
- `PREDICT_EN`, 1: 1 enables dynamic prediction; 0 forces a static not-taken prediction and leaves the table untouched.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_pc` in PC_W: PC of the instruction being fetched.
- `if_pred_taken` out 1: prediction for `if_pc`.
- `ex_valid` in 1: a branch instruction is in EX.
- `ex_stall` in 1: EX is held; no state update this cycle.
- `ex_pc` in PC_W: PC of the branch in EX.
- `ex_cond` in 3: condition code. 0=BEQ, 1=BNQ, 2=BLT, 3=BGE, 4=ALWAYS; codes 5-7 are treated as never-taken.
- `ex_pred_taken` in 1: prediction made at IF, carried down the pipeline.
- `zero` in 1: ALU zero flag.
- `negative` in 1: ALU sign flag.
- `pcsrc` out 1: actual branch outcome.
- `mispredict` out 1: actual outcome differs from the prediction; flush IF/ID.
- `pc_sel` out 2: selects the next PC. 00=predicted path, 01=branch target, 10=`ex_pc`+2 fall-through.
- `branch_count` out STAT_W: number of resolved branches.
- `mispredict_count` out STAT_W: number of mispredicted branches.

## Operation
- **Condition evaluation (combinational):**
  - BEQ: taken = `zero`.
  - BNQ: taken = ~`zero`.
  - BLT: taken = `negative`.
  - BGE: taken = ~`negative`.
  - ALWAYS: taken = 1.
  - Codes 5-7: taken = 0.
- **Outcome:** `pcsrc` = `ex_valid` & taken. Outputs are 0 when `ex_valid`=0.
- **Mispredict and redirect:**
  - `mispredict` = `ex_valid` & (taken != `ex_pred_taken`).
  - `pc_sel` = 01 when mispredict and taken.
  - `pc_sel` = 10 when mispredict and not taken.
  - `pc_sel` = 00 otherwise.
- **Prediction (combinational read of the registered table):** `if_pred_taken` = MSB of `table[if_pc[IDX_W:1]]`. Forced to 0 when `PREDICT_EN`=0.
- **Training:** on a rising edge with `ex_valid`=1 and `ex_stall`=0, `table[ex_pc[IDX_W:1]]` is updated.
  - Increment if taken, saturating at 2^CNT_W-1.
  - Decrement if not taken, saturating at 0.
  - Exactly one entry changes per cycle. With `PREDICT_EN`=0 there are no writes.
- **Statistics:** on the same qualifying edge:
  - `branch_count` increments.
  - `mispredict_count` increments if `mispredict`=1.
  - Both saturate at 2^STAT_W-1 and never wrap.
- **Aliasing:** PCs that share index bits share an entry. This is accepted and there is no tag check.

## Timing
- **Reset:** while `rst_n`=0, all table entries are held at weakly-not-taken, 2^(CNT_W-1)-1 (value 1 for CNT_W=2). Both stats are 0. Asynchronous assertion takes effect immediately, mid-operation; an update pending at that edge is discarded. Deassertion is sampled at the next rising edge.
- **Output reset values:**
  - `if_pred_taken`=0.
  - `pcsrc`, `mispredict`, `pc_sel` follow their inputs combinationally; they are 0/00 when `ex_valid`=0.
  - `branch_count`=0, `mispredict_count`=0.
- **Latency:**
  - `pcsrc`, `mispredict`, `pc_sel`: 0 cycles (combinational from EX inputs).
  - Table and statistics updates: visible 1 cycle after the qualifying edge.
- **Same-cycle read/write:** when `if_pc` and `ex_pc` map to the same index in the same cycle, `if_pred_taken` uses the pre-update value. There is no bypass.
- **Stall:** `ex_stall`=1 with `ex_valid`=1 still drives `pcsrc`, `mispredict` and `pc_sel` combinationally, but no table or statistics update occurs. The branch updates state once, on the cycle EX releases.
- **Saturation boundaries:**
  - A counter at max that sees a taken branch stays at max.
  - A counter at 0 that sees a not-taken branch stays at 0.
  - A stats counter at max holds.

## Test plan
- **Reset and initial prediction:** pulse `rst_n` low mid-cycle, then release. Required: all stats 0 immediately; `if_pred_taken`=0 for every `if_pc`.
- **Condition evaluation:** `ex_valid`=1, `ex_pred_taken`=0, then sweep `ex_cond` 0-7 across all four `zero`/`negative` combinations. Required:
  - `pcsrc` matches the condition table.
  - cond=4 → `pcsrc`=1, `pc_sel`=01.
  - cond=5 → `pcsrc`=0, `pc_sel`=00.
- **Training sequence:** three taken BEQs at `ex_pc`=0x0010 with `zero`=1 and `ex_pred_taken` tracking `if_pred_taken`. Required, for `if_pc`=0x0010 after each edge:
  - Counter goes 1→2→3→3 (saturated).
  - `if_pred_taken` = 1 after the first update.
  - `mispredict`=1 only on the first branch; final `mispredict_count`=1, `branch_count`=3.
- **Fall-through recovery:** with entry 0x0010 at 3, issue BNQ with `zero`=1 and `ex_pred_taken`=1. Required: `mispredict`=1, `pc_sel`=10, `pcsrc`=0, and the counter goes to 2.
- **Stall and same-index read:** hold `ex_stall`=1 for 3 cycles with a taken branch while `if_pc`=`ex_pc`. Required:
  - No count changes during the stall.
  - One update on release.
  - `if_pred_taken` reflects the old value in the update cycle and the new value one cycle later.
- **Saturation and static mode:** with `STAT_W`=4, run 20 branches. Required: `branch_count` stays at 15. With `PREDICT_EN`=0, required: `if_pred_taken` is always 0 and the table is unchanged after taken branches.

Source files
------------

// File: rtl/branch_predict_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_predict_unit                                                      |
// | EX branch resolution plus a PC-indexed saturating-counter predictor.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module branch_predict_unit #(
  parameter int PC_W       = 16,
  parameter int IDX_W      = 4,
  parameter int CNT_W      = 2,
  parameter int STAT_W     = 16,
  parameter int PREDICT_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [2:0]        ex_cond,
  input  logic              ex_pred_taken,
  input  logic              zero,
  input  logic              negative,
  output logic              pcsrc,
  output logic              mispredict,
  output logic [1:0]        pc_sel,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int                c_entries  = 1 << IDX_W;
  localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
  localparam logic [CNT_W-1:0]  c_cnt_init = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [STAT_W-1:0] c_stat_max = '1;

  logic              w_taken;
  logic              w_mispredict;
  logic              w_update;
  logic              w_table_we;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_unused_pc_bits;
  logic [CNT_W-1:0]  r_table [c_entries];
  logic [STAT_W-1:0] r_branch_count;
  logic [STAT_W-1:0] r_mispredict_count;

  always_comb begin
    w_taken = 1'b0;
    case (ex_cond)
      3'd0:    w_taken = zero;
      3'd1:    w_taken = ~zero;
      3'd2:    w_taken = negative;
      3'd3:    w_taken = ~negative;
      3'd4:    w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign pcsrc        = ex_valid & w_taken;
  assign w_mispredict = ex_valid & (w_taken != ex_pred_taken);
  assign mispredict   = w_mispredict;

  always_comb begin
    pc_sel = 2'b00;
    if (w_mispredict) begin
      pc_sel = w_taken ? 2'b01 : 2'b10;
    end
  end

  // A stalled branch must not train or count until EX releases it.
  assign w_update   = ex_valid & ~ex_stall;
  assign w_table_we = w_update & (PREDICT_EN != 0);
  assign w_rd_idx   = if_pc[IDX_W:1];
  assign w_wr_idx   = ex_pc[IDX_W:1];

  assign w_unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+1], if_pc[0],
                              ex_pc[PC_W-1:IDX_W+1], ex_pc[0]};

  generate
    for (genvar gi = 0; gi < c_entries; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_table[gi] <= c_cnt_init;
        end else if (w_table_we && (w_wr_idx == IDX_W'(gi))) begin
          if (w_taken) begin
            if (r_table[gi] != c_cnt_max) r_table[gi] <= r_table[gi] + CNT_W'(1);
          end else begin
            if (r_table[gi] != '0) r_table[gi] <= r_table[gi] - CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  // Read of the registered table: a same-index write this cycle is not bypassed.
  generate
    if (PREDICT_EN != 0) begin : g_dynamic
      assign if_pred_taken = r_table[w_rd_idx][CNT_W-1];
    end else begin : g_static
      assign if_pred_taken = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_update) begin
      if (r_branch_count != c_stat_max) begin
        r_branch_count <= r_branch_count + STAT_W'(1);
      end
      if (w_mispredict && (r_mispredict_count != c_stat_max)) begin
        r_mispredict_count <= r_mispredict_count + STAT_W'(1);
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_predict_unit                                                   |
// | Directed bench: default, STAT_W=4 and static-prediction instances.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] if_pc;
  logic        ex_valid;
  logic        ex_stall;
  logic [15:0] ex_pc;
  logic [2:0]  ex_cond;
  logic        ex_pred_taken;
  logic        zero;
  logic        negative;

  logic        m_if_pred_taken, m_pcsrc, m_mispredict;
  logic [1:0]  m_pc_sel;
  logic [15:0] m_branch_count, m_mispredict_count;
  logic        s_if_pred_taken, s_pcsrc, s_mispredict;
  logic [1:0]  s_pc_sel;
  logic [3:0]  s_branch_count, s_mispredict_count;
  logic        t_if_pred_taken, t_pcsrc, t_mispredict;
  logic [1:0]  t_pc_sel;
  logic [15:0] t_branch_count, t_mispredict_count;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(m_if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_cond(ex_cond),
    .ex_pred_taken(ex_pred_taken), .zero(zero), .negative(negative),
    .pcsrc(m_pcsrc), .mispredict(m_mispredict), .pc_sel(m_pc_sel),
    .branch_count(m_branch_count), .mispredict_count(m_mispredict_count)
  );

  branch_predict_unit #(.STAT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(s_if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_cond(ex_cond),
    .ex_pred_taken(ex_pred_taken), .zero(zero), .negative(negative),
    .pcsrc(s_pcsrc), .mispredict(s_mispredict), .pc_sel(s_pc_sel),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  branch_predict_unit #(.PREDICT_EN(0)) dut_static (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(t_if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_cond(ex_cond),
    .ex_pred_taken(ex_pred_taken), .zero(zero), .negative(negative),
    .pcsrc(t_pcsrc), .mispredict(t_mispredict), .pc_sel(t_pc_sel),
    .branch_count(t_branch_count), .mispredict_count(t_mispredict_count)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: counter for the trained entry and the statistics.
  logic [1:0] cnt;
  int         bcnt, mcnt, sb, sm;

  function automatic logic cond_model(input int c, input logic z, input logic n);
    case (c)
      0:       return z;
      1:       return !z;
      2:       return n;
      3:       return !n;
      4:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      x = q.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic model_reset();
    cnt = 2'd1;
    bcnt = 0; mcnt = 0; sb = 0; sm = 0;
  endtask

  // One qualifying branch with if_pc == ex_pc; inputs already driven.
  task automatic branch_step(input logic tk);
    logic mp;
    mp = (tk != ex_pred_taken);
    push("mispredict", {31'b0, mp});        pop_check({31'b0, m_mispredict});
    push("pred_before_edge", {31'b0, cnt[1]}); pop_check({31'b0, m_if_pred_taken});
    bcnt++;
    if (mp) mcnt++;
    if (sb < 15) sb++;
    if (mp && sm < 15) sm++;
    if (tk && cnt != 2'd3) cnt = cnt + 2'd1;
    else if (!tk && cnt != 2'd0) cnt = cnt - 2'd1;
    push("pred_after_edge", {31'b0, cnt[1]});
    push("branch_count", bcnt);
    push("mispredict_count", mcnt);
    push("sat_branch_count", sb);
    push("sat_mispredict_count", sm);
    push("static_pred", 0);
    @(posedge clk); #1;
    pop_check({31'b0, m_if_pred_taken});
    pop_check({16'b0, m_branch_count});
    pop_check({16'b0, m_mispredict_count});
    pop_check({28'b0, s_branch_count});
    pop_check({28'b0, s_mispredict_count});
    pop_check({31'b0, t_if_pred_taken});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic tk;
    if_pc = '0; ex_valid = 0; ex_stall = 0; ex_pc = '0; ex_cond = '0;
    ex_pred_taken = 0; zero = 0; negative = 0;
    model_reset();

    // Reset: stats zero and not-taken prediction everywhere.
    #1 rst_n = 1'b0;
    #1;
    push("rst_branch_count", 0);     pop_check({16'b0, m_branch_count});
    push("rst_mispredict_count", 0); pop_check({16'b0, m_mispredict_count});
    for (int i = 0; i < 16; i++) begin
      if_pc = 16'(i << 1);
      #1;
      push("rst_pred", 0); pop_check({31'b0, m_if_pred_taken});
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Condition sweep under stall so nothing trains.
    ex_valid = 1; ex_stall = 1; ex_pred_taken = 0;
    for (int c = 0; c < 8; c++) begin
      for (int zn = 0; zn < 4; zn++) begin
        ex_cond = 3'(c); zero = zn[0]; negative = zn[1];
        #1;
        tk = cond_model(c, zn[0], zn[1]);
        push("pcsrc", {31'b0, tk});          pop_check({31'b0, m_pcsrc});
        push("sweep_mispredict", {31'b0, tk}); pop_check({31'b0, m_mispredict});
        push("pc_sel", tk ? 32'd1 : 32'd0);  pop_check({30'b0, m_pc_sel});
      end
    end
    ex_valid = 0; ex_cond = 3'd4; #1;
    push("idle_pcsrc", 0);      pop_check({31'b0, m_pcsrc});
    push("idle_mispredict", 0); pop_check({31'b0, m_mispredict});
    push("idle_pc_sel", 0);     pop_check({30'b0, m_pc_sel});
    @(posedge clk); #1;
    push("sweep_no_count", 0);  pop_check({16'b0, m_branch_count});

    // Training: three taken BEQs at 0x0010.
    ex_pc = 16'h0010; if_pc = 16'h0010; ex_cond = 3'd0; zero = 1; negative = 0;
    ex_valid = 1; ex_stall = 0;
    repeat (3) begin
      ex_pred_taken = cnt[1];
      #1;
      branch_step(1'b1);
    end

    // Fall-through recovery: BNQ with zero=1, predicted taken (3 -> 2 -> 1).
    ex_cond = 3'd1; ex_pred_taken = 1;
    #1;
    push("ft_mispredict", 1); pop_check({31'b0, m_mispredict});
    push("ft_pc_sel", 2);     pop_check({30'b0, m_pc_sel});
    push("ft_pcsrc", 0);      pop_check({31'b0, m_pcsrc});
    branch_step(1'b0);
    branch_step(1'b0);

    // Stall with same-index read: counter 1, taken ALWAYS held for 3 cycles.
    ex_cond = 3'd4; ex_pred_taken = 0; ex_stall = 1;
    repeat (3) begin
      #1;
      push("stall_pcsrc", 1);  pop_check({31'b0, m_pcsrc});
      push("stall_pc_sel", 1); pop_check({30'b0, m_pc_sel});
      push("stall_branch_count", bcnt);     push("stall_mispredict_count", mcnt);
      push("stall_pred", {31'b0, cnt[1]});
      @(posedge clk); #1;
      pop_check({16'b0, m_branch_count});
      pop_check({16'b0, m_mispredict_count});
      pop_check({31'b0, m_if_pred_taken});
    end
    ex_stall = 0;
    #1;
    branch_step(1'b1);

    // Mid-cycle asynchronous reset with a taken update pending.
    ex_pred_taken = 1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    push("async_branch_count", 0);     pop_check({16'b0, m_branch_count});
    push("async_mispredict_count", 0); pop_check({16'b0, m_mispredict_count});
    push("async_pred", 0);             pop_check({31'b0, m_if_pred_taken});
    push("async_sat_count", 0);        pop_check({28'b0, s_branch_count});
    ex_valid = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push("post_reset_pred", 0);        pop_check({31'b0, m_if_pred_taken});

    // Saturation of the 4-bit stats and static mode stays not-taken.
    ex_valid = 1; ex_cond = 3'd4;
    repeat (20) begin
      ex_pred_taken = cnt[1];
      #1;
      branch_step(1'b1);
    end
    push("final_sat_branch_count", 15); pop_check({28'b0, s_branch_count});
    push("final_branch_count", 20);     pop_check({16'b0, m_branch_count});
    ex_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
